freqdiv_ctrl: RTL and testbench
===============================

FREQDIV_CTRL -- requirements
Module: freqdiv_ctrl

Interface
REQ-001 The block SHALL take parameter WIDTH, default 8, the width of the divide-ratio field.
REQ-002 The block SHALL take parameter DEFAULT_DIV, default 1, the divide ratio loaded at reset.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port run, input, 1 bit: level request to generate clk_out.
REQ-006 The block SHALL have port div_in, input, WIDTH bits: requested ratio D; clk_out toggles every D+1 clk cycles.
REQ-007 The block SHALL have port cfg_valid, input, 1 bit: div_in is valid.
REQ-008 The block SHALL have port cfg_ready, output, 1 bit: the block can accept a ratio.
REQ-009 The block SHALL have port clk_out, output, 1 bit: registered divided clock, period 2*(cur_div+1).
REQ-010 The block SHALL have port tick, output, 1 bit: one-cycle pulse in each cycle where clk_out goes 0 to 1.
REQ-011 The block SHALL have port cur_div, output, WIDTH bits: the ratio currently in effect.
REQ-012 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-013 The block SHALL have port period_cnt, output, 16 bits: count of completed clk_out periods.

Function
REQ-014 FSM states SHALL be: IDLE, RUN, PEND (running, new ratio held) and STOP (finishing the high phase).
REQ-015 Internal counter cnt (WIDTH bits) SHALL count 0..cur_div in RUN, PEND and STOP; at cnt==cur_div, clk_out toggles and cnt goes to 0.
REQ-016 A handshake (cfg_valid & cfg_ready) SHALL copy div_in into register pend_div.
REQ-017 cfg_ready SHALL be 1 in IDLE and RUN, and 0 in PEND and STOP while a pending ratio exists.
REQ-018 In IDLE, a handshake SHALL load cur_div on the next edge; no other state change occurs.
REQ-019 In RUN, a handshake SHALL move the FSM to PEND.
REQ-020 Period boundary definition: a boundary is a clk_out 1 to 0 transition (cnt==cur_div with clk_out==1).
REQ-021 A ratio SHALL be applied only at a period boundary; cur_div<=pend_div, cnt<=0, PEND goes to RUN.
REQ-022 A handshake in the same cycle as a boundary SHALL be applied at the following boundary, not the current one.
REQ-023 IDLE with run=1 SHALL go to RUN with cnt=0, clk_out=0; the first rise comes after cur_div+1 cycles.
REQ-024 run=0 in RUN or PEND with clk_out=0 SHALL go to IDLE on the next edge, with cnt=0 and clk_out held at 0.
REQ-025 run=0 in RUN or PEND with clk_out=1 SHALL go to STOP, complete the high phase, then go to IDLE at the boundary.
REQ-026 Any held ratio SHALL be applied on entry to IDLE.
REQ-027 In STOP, run re-asserting SHALL NOT abort the stop; the FSM reaches IDLE, then restarts per REQ-023.
REQ-028 run falling and a handshake in the same cycle SHALL both take effect: the ratio is held and applied on entry to IDLE.
REQ-029 period_cnt SHALL increment by 1 at each boundary and wrap from 0xFFFF to 0x0000.
REQ-030 Ratio D=0 SHALL be legal: clk_out = clk/2, tick every 2 cycles.
REQ-031 The max ratio SHALL be 2^WIDTH-1, with no overflow on cnt.
REQ-032 clk_out SHALL never show a high or low phase shorter than min(old,new)+1 cycles (glitch-free).

Reset
REQ-033 On reset=1 at a clk edge, the FSM SHALL go to IDLE regardless of state, aborting mid-period.
REQ-034 Reset SHALL set cnt=0, clk_out=0, tick=0, busy=0, cfg_ready=1, period_cnt=0 and cur_div=DEFAULT_DIV, and discard pend_div.
REQ-035 While reset is high, handshakes SHALL be ignored; run is sampled again only after reset falls.

Verification
REQ-036 Reset, then run=1 with default D=1 -> clk_out 0,0,1,1 repeating; tick every 4 cycles; period_cnt increments every 4 cycles.
REQ-037 IDLE handshake with div_in=3, then run=1 -> clk_out high 4 and low 4 cycles; cur_div=3 one cycle after the handshake.
REQ-038 Running at D=2 with a handshake for D=0 mid high phase -> cfg_ready=0 until the boundary; the phase finishes 3 cycles long; then clk_out toggles every cycle.
REQ-039 run dropped while clk_out=1 at cnt=0 with D=4 -> 4 more high cycles, STOP then IDLE, clk_out=0, busy=0; run dropped while clk_out=0 -> IDLE next cycle.
REQ-040 Handshake coincident with a boundary, D 1->5 -> the next period still uses D=1, the period after uses D=5; period_cnt preloaded 0xFFFF wraps to 0.
REQ-041 Reset asserted mid PEND -> next cycle IDLE, cur_div=DEFAULT_DIV, pending discarded, all outputs at reset values.

Source files
------------

// File: rtl/freqdiv_ctrl.sv
// freqdiv_ctrl: programmable clock divider with a ratio handshake.
// clk_out toggles every cur_div+1 clk cycles. New ratios are taken on a
// valid/ready handshake and only take effect at a clk_out 1->0 boundary
// (or on entry to IDLE), so no phase is ever shortened. Stopping while
// clk_out is high finishes the high phase first.
module freqdiv_ctrl #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned DEFAULT_DIV = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [WIDTH-1:0] div_in,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    output logic             clk_out,
    output logic             tick,
    output logic [WIDTH-1:0] cur_div,
    output logic             busy,
    output logic [15:0]      period_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PEND,
        STOP
    } state_t;

    localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;
    logic [WIDTH-1:0] cur_div_q, cur_div_d;
    logic [WIDTH-1:0] pend_div_q, pend_div_d;
    logic             pend_vld_q, pend_vld_d;
    logic [15:0]      period_q, period_d;

    logic             hs;
    logic             at_end;
    logic             have_held;
    logic [WIDTH-1:0] held_div;

    // A pending ratio blocks further handshakes until it has been applied.
    assign cfg_ready  = ~pend_vld_q;
    assign hs         = cfg_valid & cfg_ready;
    assign at_end     = (cnt_q == cur_div_q);
    // Ratio to install on entry to IDLE: a same-cycle handshake wins,
    // otherwise whatever is already held.
    assign have_held  = hs | pend_vld_q;
    assign held_div   = hs ? div_in : pend_div_q;

    assign clk_out    = clk_out_q;
    assign tick       = tick_q;
    assign cur_div    = cur_div_q;
    assign busy       = (state_q != IDLE);
    assign period_cnt = period_q;

    // Next-state, counter, phase and ratio bookkeeping.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        clk_out_d  = clk_out_q;
        cur_div_d  = cur_div_q;
        pend_div_d = pend_div_q;
        pend_vld_d = pend_vld_q;
        period_d   = period_q;

        if (hs) begin
            pend_div_d = div_in;
        end

        case (state_q)
            IDLE: begin
                if (hs) begin
                    cur_div_d = div_in;
                end
                if (run) begin
                    state_d   = RUN;
                    cnt_d     = '0;
                    clk_out_d = 1'b0;
                end
            end

            RUN, PEND: begin
                if (!run && !clk_out_q) begin
                    // Low phase: stop immediately, clk_out stays low.
                    state_d   = IDLE;
                    cnt_d     = '0;
                    clk_out_d = 1'b0;
                    if (have_held) begin
                        cur_div_d = held_div;
                    end
                    pend_vld_d = 1'b0;
                end else begin
                    if (hs) begin
                        pend_vld_d = 1'b1;
                        state_d    = PEND;
                    end
                    if (at_end) begin
                        cnt_d     = '0;
                        clk_out_d = ~clk_out_q;
                        if (clk_out_q) begin
                            period_d = period_q + 16'd1;
                            if (!run) begin
                                state_d = IDLE;
                                if (have_held) begin
                                    cur_div_d = held_div;
                                end
                                pend_vld_d = 1'b0;
                            end else if (state_q == PEND) begin
                                // A ratio accepted this very cycle is not
                                // pending yet (state_q is RUN), so it waits
                                // for the following boundary.
                                cur_div_d  = pend_div_q;
                                pend_vld_d = 1'b0;
                                state_d    = RUN;
                            end
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        if (!run) begin
                            state_d = STOP;
                        end
                    end
                end
            end

            STOP: begin
                if (hs) begin
                    pend_vld_d = 1'b1;
                end
                if (at_end) begin
                    cnt_d     = '0;
                    clk_out_d = 1'b0;
                    period_d  = period_q + 16'd1;
                    state_d   = IDLE;
                    if (have_held) begin
                        cur_div_d = held_div;
                    end
                    pend_vld_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        tick_d = ~clk_out_q & clk_out_d;
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            clk_out_q  <= 1'b0;
            tick_q     <= 1'b0;
            cur_div_q  <= DEF_DIV;
            pend_div_q <= '0;
            pend_vld_q <= 1'b0;
            period_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            clk_out_q  <= clk_out_d;
            tick_q     <= tick_d;
            cur_div_q  <= cur_div_d;
            pend_div_q <= pend_div_d;
            pend_vld_q <= pend_vld_d;
            period_q   <= period_d;
        end
    end

endmodule

// File: tb/tb_freqdiv_ctrl.sv
// Testbench for freqdiv_ctrl: a phase-level reference model predicts the
// outputs after every clock edge; a monitor compares them to the DUT.
module tb_freqdiv_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       run;
    logic [7:0] div_in;
    logic       cfg_valid;
    logic       cfg_ready;
    logic       clk_out;
    logic       tick;
    logic [7:0] cur_div;
    logic       busy;
    logic [15:0] period_cnt;

    freqdiv_ctrl #(
        .WIDTH(8),
        .DEFAULT_DIV(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .run(run),
        .div_in(div_in),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .clk_out(clk_out),
        .tick(tick),
        .cur_div(cur_div),
        .busy(busy),
        .period_cnt(period_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ready;
        int level;
        int tck;
        int div;
        int bsy;
        int per;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: phases measured as cycles remaining.
    bit   m_active, m_stop, m_level, m_tick;
    int   m_left, m_div, m_per;
    int   m_pend[$];

    task automatic model_reset();
        m_active = 0; m_stop = 0; m_level = 0; m_tick = 0;
        m_left = 0; m_div = 1; m_per = 0;
        m_pend.delete();
    endtask

    task automatic model_idle();
        m_active = 0; m_stop = 0; m_level = 0; m_tick = 0;
        if (m_pend.size() > 0) m_div = m_pend.pop_front();
    endtask

    task automatic model_step(input bit r, input bit rn, input bit v, input int d);
        bit hs;
        bit old_level;
        hs = v && (m_pend.size() == 0) && !r;
        if (r) begin
            model_reset();
        end else if (!m_active) begin
            if (hs) m_div = d;
            m_tick = 0;
            if (rn) begin
                m_active = 1; m_level = 0; m_left = m_div + 1;
            end
        end else if (!m_stop && !rn && !m_level) begin
            if (hs) m_pend.push_back(d);
            model_idle();
        end else begin
            if (m_left == 1) begin
                old_level = m_level;
                m_level = !m_level;
                if (old_level) begin
                    m_per = (m_per + 1) % 65536;
                    if (m_stop || !rn) begin
                        if (hs) m_pend.push_back(d);
                        model_idle();
                    end else if (m_pend.size() > 0) begin
                        m_div = m_pend.pop_front();
                    end
                end
                if (hs && m_active) m_pend.push_back(d);
                m_left = m_div + 1;
                m_tick = m_level;
                if (!m_active) m_tick = 0;
            end else begin
                if (hs) m_pend.push_back(d);
                m_left--;
                m_tick = 0;
                if (!rn) m_stop = 1;
            end
        end
    endtask

    task automatic step(input bit r, input bit rn, input bit v, input int d);
        exp_t e;
        @(negedge clk);
        reset = r; run = rn; cfg_valid = v; div_in = 8'(d);
        model_step(r, rn, v, d);
        e.ready = (m_pend.size() == 0) ? 1 : 0;
        e.level = m_level;
        e.tck   = m_tick;
        e.div   = m_div;
        e.bsy   = m_active;
        e.per   = m_per;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, expv);
        end
    endtask

    // Monitor: compare every post-edge DUT state against the next prediction.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("cfg_ready",  int'(cfg_ready),  e.ready);
                chk("clk_out",    int'(clk_out),    e.level);
                chk("tick",       int'(tick),       e.tck);
                chk("cur_div",    int'(cur_div),    e.div);
                chk("busy",       int'(busy),       e.bsy);
                chk("period_cnt", int'(period_cnt), e.per);
            end
        end
    end

    initial begin
        int n;
        bit rn;
        reset = 1'b1; run = 1'b0; cfg_valid = 1'b0; div_in = '0;
        model_reset();

        // Reset state, then default ratio D=1.
        repeat (2) step(1, 0, 0, 0);
        repeat (14) step(0, 1, 0, 0);
        repeat (8) step(0, 0, 0, 0);

        // Ratio 3 loaded in IDLE, then run.
        step(0, 0, 1, 3);
        repeat (20) step(0, 1, 0, 0);
        repeat (10) step(0, 0, 0, 0);

        // D=2 with a switch to D=0 during the high phase.
        step(0, 0, 1, 2);
        repeat (4) step(0, 1, 0, 0);
        step(0, 1, 1, 0);
        repeat (12) step(0, 1, 0, 0);
        repeat (4) step(0, 0, 0, 0);

        // D=4: stop during the high phase at cnt=0, then during low phase.
        step(0, 0, 1, 4);
        repeat (6) step(0, 1, 0, 0);
        repeat (10) step(0, 0, 0, 0);
        repeat (3) step(0, 1, 0, 0);
        repeat (3) step(0, 0, 0, 0);

        // D=1, handshake exactly at a boundary for D=5.
        step(0, 0, 1, 1);
        n = 0;
        while (n < 20) begin
            if (m_active && m_level && m_left == 1) begin
                step(0, 1, 1, 5);
                n = 100;
            end else begin
                step(0, 1, 0, 0);
                n++;
            end
        end
        repeat (20) step(0, 1, 0, 0);

        // Handshake while running, then reset while pending.
        step(0, 1, 1, 7);
        step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        repeat (3) step(0, 0, 1, 9);

        // Run falls together with a handshake.
        repeat (5) step(0, 1, 0, 0);
        step(0, 0, 1, 2);
        repeat (8) step(0, 0, 0, 0);

        // Randomized traffic, including the maximum ratio.
        rn = 1;
        for (int i = 0; i < 3000; i++) begin
            int d;
            if ($urandom_range(0, 39) == 0) rn = !rn;
            d = ($urandom_range(0, 15) == 0) ? 255 : int'($urandom_range(0, 5));
            step(($urandom_range(0, 499) == 0), rn,
                 ($urandom_range(0, 7) == 0), d);
        end

        step(0, 0, 0, 0);
        n = 0;
        while (exp_q.size() > 0 && n < 10) begin
            @(posedge clk);
            n++;
        end
        #2;
        if (exp_q.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d predictions left unchecked, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
